// File: rtl/phase_sequencer.sv
// Automatic phase-scan sequencer: arms and triggers the phase controller, then
// steps it through a programmed number of phases while watching its feedback.
module phase_sequencer #(
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_delay_cycles,
  input  logic [31:0] i_dwell_cycles,
  input  logic [5:0]  i_num_steps,
  input  logic [1:0]  i_controller_state,
  input  logic        i_output_on,
  output logic        o_armed,
  output logic        o_trigger_out,
  output logic        o_change_phase_out,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [5:0]  o_step_count,
  output logic [2:0]  o_seq_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DELAY = 3'd1, S_TRIG = 3'd2, S_WAIT_ON = 3'd3,
    S_DWELL = 3'd4, S_STEP = 3'd5, S_FINISH = 3'd6, S_FAULT = 3'd7
  } state_t;

  localparam logic [31:0] PULSE_LAST = 32'(PULSE_LEN - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);
  localparam logic [1:0]  CS_ON      = 2'b10;

  state_t      r_state, w_nxt;
  logic [31:0] r_cnt, r_delay, r_dwell;
  logic [5:0]  r_nsteps, r_step_count;
  logic        r_left_on, r_error;
  logic        r_armed, r_trig, r_cp, r_busy, r_done;
  logic        w_armed, w_trig, w_cp, w_busy, w_done;
  logic [31:0] w_delay_last, w_dwell_last;
  logic        w_start_ok, w_step_entry, w_on_ok, w_dropout;

  // A programmed count of 0 behaves as 1, so the terminal index is max(n,1)-1.
  assign w_delay_last = (r_delay == 32'd0) ? 32'd0 : r_delay - 32'd1;
  assign w_dwell_last = (r_dwell == 32'd0) ? 32'd0 : r_dwell - 32'd1;
  assign w_start_ok   = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_step_entry = (w_nxt == S_STEP) && (r_state != S_STEP);
  assign w_dropout    = (i_controller_state == 2'b00) || (i_controller_state == 2'b11);
  // After a step the controller must visibly leave ON before a new ON counts.
  assign w_on_ok      = (i_controller_state == CS_ON) && i_output_on &&
                        ((r_step_count == 6'd0) || r_left_on);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_nxt = S_DELAY;
      S_DELAY:   if (r_cnt == w_delay_last) w_nxt = S_TRIG;
      S_TRIG:    if (r_cnt == PULSE_LAST) w_nxt = S_WAIT_ON;
      S_WAIT_ON: if (r_cnt == TO_LAST) w_nxt = S_FAULT;
                 else if (w_on_ok) w_nxt = S_DWELL;
      S_DWELL:   if (w_dropout) w_nxt = S_FAULT;
                 else if (r_cnt == w_dwell_last)
                   w_nxt = (r_step_count == r_nsteps) ? S_FINISH : S_STEP;
      S_STEP:    if (r_cnt == PULSE_LAST) w_nxt = S_WAIT_ON;
      S_FINISH:  w_nxt = S_IDLE;
      S_FAULT:   w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
    if (i_abort && r_state != S_IDLE) w_nxt = S_IDLE;
  end

  always_comb begin
    w_armed = 1'b0;
    w_trig  = 1'b0;
    w_cp    = 1'b0;
    w_done  = 1'b0;
    w_busy  = (w_nxt != S_IDLE);
    case (w_nxt)
      S_DELAY, S_WAIT_ON, S_DWELL: w_armed = 1'b1;
      S_TRIG:   begin w_armed = 1'b1; w_trig = 1'b1; end
      S_STEP:   begin w_armed = 1'b1; w_cp = 1'b1; end
      S_FINISH: w_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_delay      <= '0;
      r_dwell      <= '0;
      r_nsteps     <= '0;
      r_step_count <= '0;
      r_error      <= 1'b0;
      r_left_on    <= 1'b0;
      r_armed      <= 1'b0;
      r_trig       <= 1'b0;
      r_cp         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cnt <= (w_nxt != r_state || r_state == S_IDLE) ? 32'd0 : r_cnt + 32'd1;
      if (w_start_ok) begin
        r_delay      <= i_delay_cycles;
        r_dwell      <= i_dwell_cycles;
        r_nsteps     <= i_num_steps;
        r_step_count <= '0;
        r_error      <= 1'b0;
      end else begin
        if (w_step_entry && r_step_count != 6'd63) r_step_count <= r_step_count + 6'd1;
        if (w_nxt == S_FAULT) r_error <= 1'b1;
      end
      if (w_step_entry) r_left_on <= 1'b0;
      else if ((r_state == S_STEP || r_state == S_WAIT_ON) && i_controller_state != CS_ON)
        r_left_on <= 1'b1;
      r_armed <= w_armed;
      r_trig  <= w_trig;
      r_cp    <= w_cp;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign o_armed            = r_armed;
  assign o_trigger_out      = r_trig;
  assign o_change_phase_out = r_cp;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_step_count       = r_step_count;
  assign o_seq_state        = r_state;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: behavioural controller model, per-run
// expectations queued at start and compared when the sequencer returns to idle.
module tb_phase_sequencer;
  localparam int PL = 4;
  localparam int TO = 1024;

  typedef struct { int trig; int cp; int steps; int done; int err; } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] dly, dwl;
  logic [5:0]  nst;
  logic [1:0]  cs;
  logic        on;
  logic        o_armed, o_trig, o_cp, o_busy, o_done, o_error;
  logic [5:0]  o_step;
  logic [2:0]  o_state;

  logic [1:0]  m_cs = 2'b00;
  logic        m_on = 1'b0;
  bit          m_never = 1'b0, m_force = 1'b0, m_wchk = 1'b1;
  logic [1:0]  m_fv = 2'b00;

  int n_pass = 0, n_tot = 0;
  int trig_cnt = 0, cp_cnt = 0, done_cnt = 0;
  int s_trig, s_cp, s_done;
  exp_t sb[$];

  assign cs = m_force ? m_fv : m_cs;
  assign on = m_on;

  always #5 clk = ~clk;

  phase_sequencer #(.PULSE_LEN(PL), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_delay_cycles(dly), .i_dwell_cycles(dwl), .i_num_steps(nst),
    .i_controller_state(cs), .i_output_on(on),
    .o_armed(o_armed), .o_trigger_out(o_trig), .o_change_phase_out(o_cp),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_step_count(o_step), .o_seq_state(o_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Controller model: FIND_PHASE on each trigger/change edge, ON three cycles later.
  initial begin
    bit pt, pc;
    int mc;
    pt = 0; pc = 0; mc = 0;
    forever @(negedge clk) begin
      if (!o_armed) begin m_cs = 2'b00; m_on = 1'b0; mc = 0; end
      else if ((o_trig && !pt) || (o_cp && !pc)) begin m_cs = 2'b01; m_on = 1'b0; mc = 3; end
      else if (mc > 0) begin
        mc--;
        if (mc == 0 && !m_never) begin m_cs = 2'b10; m_on = 1'b1; end
      end
      pt = o_trig;
      pc = o_cp;
    end
  end

  // Pulse monitor: counts edges, checks widths and done/armed coincidence.
  initial begin
    bit pt, pc;
    int tw, cw;
    pt = 0; pc = 0; tw = 0; cw = 0;
    forever @(negedge clk) begin
      if (o_trig) begin if (!pt) trig_cnt++; tw++; end
      else if (tw != 0) begin chk("trig_width", tw, PL); tw = 0; end
      if (o_cp) begin if (!pc) cp_cnt++; cw++; end
      else if (cw != 0) begin if (m_wchk) chk("cp_width", cw, PL); cw = 0; end
      if (o_done) begin done_cnt++; chk("armed_at_done", o_armed, 0); end
      pt = o_trig;
      pc = o_cp;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on the negedge the trigger is first seen.
  task automatic begin_run(input int d, input int dw, input int ns, input bit hold,
                           input bit push, input exp_t e);
    int k;
    if (push) sb.push_back(e);
    s_trig = trig_cnt; s_cp = cp_cnt; s_done = done_cnt;
    dly = d; dwl = dw; nst = 6'(ns); start = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!hold) start = 1'b0;
    chk("armed_after_start", o_armed, 1);
    chk("busy_after_start", o_busy, 1);
    chk("state_delay", o_state, 1);
    chk("error_cleared", o_error, 0);
    chk("step_cleared", o_step, 0);
    k = 0;
    while (!o_trig && k < 300) begin @(negedge clk); k++; end
    chk("trig_latency", k, (d == 0) ? 1 : d);
  endtask

  task automatic end_run();
    exp_t e;
    int k;
    k = 0;
    while (o_busy && k < 20000) begin @(negedge clk); k++; end
    chk("idle_reached", o_busy, 0);
    chk("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("trig_pulses", trig_cnt - s_trig, e.trig);
      chk("cp_pulses", cp_cnt - s_cp, e.cp);
      chk("done_pulses", done_cnt - s_done, e.done);
      chk("step_count", o_step, e.steps);
      chk("error", o_error, e.err);
      chk("armed_idle", o_armed, 0);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int k;
    k = 0;
    while (o_state != s && k < 5000) begin @(negedge clk); k++; end
    chk(tag, o_state, s);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dly = '0; dwl = '0; nst = '0;
    repeat (3) @(negedge clk);
    chk("rst_armed", o_armed, 0);
    chk("rst_trig", o_trig, 0);
    chk("rst_cp", o_cp, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_step", o_step, 0);
    chk("rst_state", o_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Normal scan
    begin_run(10, 20, 3, 1'b0, 1'b1, '{1, 3, 3, 1, 0});
    end_run();

    // Zero configuration
    begin_run(0, 0, 0, 1'b0, 1'b1, '{1, 0, 0, 1, 0});
    end_run();

    // Timeout: controller never reaches ON
    m_never = 1'b1;
    begin_run(2, 5, 1, 1'b0, 1'b1, '{1, 0, 0, 0, 1});
    wait_state(3'd3, "reach_wait_on");
    t = 0;
    while (o_state != 3'd7 && t < 2000) begin @(negedge clk); t++; end
    chk("timeout_cycles", t, TO);
    chk("fault_armed", o_armed, 0);
    chk("fault_error", o_error, 1);
    end_run();
    m_never = 1'b0;

    // Dropout mid-DWELL on step 2
    begin_run(2, 20, 5, 1'b0, 1'b1, '{1, 2, 2, 0, 1});
    t = 0;
    while (!(o_step == 6'd2 && o_state == 3'd4) && t < 5000) begin @(negedge clk); t++; end
    chk("reach_dwell2", o_state, 4);
    repeat (5) @(negedge clk);
    m_fv = 2'b11; m_force = 1'b1;
    @(negedge clk);
    chk("dropout_fault", o_state, 7);
    chk("dropout_step", o_step, 2);
    chk("dropout_error", o_error, 1);
    m_force = 1'b0;
    end_run();

    // Abort during a STEP pulse
    begin_run(2, 10, 3, 1'b0, 1'b1, '{1, 1, 1, 0, 0});
    wait_state(3'd5, "reach_step");
    chk("cp_in_step", o_cp, 1);
    m_wchk = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_cp", o_cp, 0);
    chk("abort_armed", o_armed, 0);
    chk("abort_state", o_state, 0);
    chk("abort_step", o_step, 1);
    abort = 1'b0;
    end_run();
    m_wchk = 1'b1;

    // start held through a whole run is only sampled in IDLE
    begin_run(3, 6, 2, 1'b1, 1'b1, '{1, 2, 2, 1, 0});
    t = 0;
    while (!o_done && t < 5000) begin @(negedge clk); t++; end
    chk("hold_done", o_done, 1);
    chk("hold_finish_state", o_state, 6);
    start = 1'b0;
    end_run();

    // start with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("start_abort_state", o_state, 0);
      chk("start_abort_busy", o_busy, 0);
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);

    // Asynchronous reset between edges while in DWELL
    begin_run(3, 30, 2, 1'b0, 1'b0, '{0, 0, 0, 0, 0});
    wait_state(3'd4, "reach_dwell_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_armed", o_armed, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_state", o_state, 0);
    chk("arst_trig", o_trig, 0);
    chk("arst_cp", o_cp, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", o_state, 0);
    end

    begin_run(0, 0, 0, 1'b0, 1'b1, '{1, 0, 0, 1, 0});
    end_run();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
